// File: rtl/dcache_pkg.sv
// Shared parameters, FSM state encodings and address-field helpers for the data cache controller.
// No logic; no latency; no backpressure.
package dcache_pkg;

    localparam int LINE_ADDR_LEN_DEF = 3;
    localparam int SET_ADDR_LEN_DEF  = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WB   = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;

    function automatic int tag_len(input int set_len, input int line_len);
        return 32 - set_len - line_len - 2;
    endfunction

endpackage

// File: rtl/dcache_line_ram.sv
// Direct-mapped line storage: data words, tags, valid and dirty bits.
// Combinational read, write on rising edge; valid/dirty cleared asynchronously by reset.
// No backpressure: every presented write is accepted.
module dcache_line_ram
    import dcache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
    parameter int SET_ADDR_LEN  = SET_ADDR_LEN_DEF,
    parameter int TAG_W         = tag_len(SET_ADDR_LEN_DEF, LINE_ADDR_LEN_DEF)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SET_ADDR_LEN-1:0]  rd_set,
    input  logic [LINE_ADDR_LEN-1:0] rd_word,
    output logic                     rd_valid,
    output logic                     rd_dirty,
    output logic [TAG_W-1:0]         rd_tag,
    output logic [31:0]              rd_dat,
    input  logic                     wr_word_vld,
    input  logic [SET_ADDR_LEN-1:0]  wr_set,
    input  logic [LINE_ADDR_LEN-1:0] wr_word,
    input  logic [31:0]              wr_dat,
    input  logic [3:0]               wr_be,
    input  logic                     meta_vld,
    input  logic                     meta_valid,
    input  logic                     meta_dirty,
    input  logic [TAG_W-1:0]         meta_tag
);
    localparam int NSETS  = 1 << SET_ADDR_LEN;
    localparam int NWORDS = 1 << (SET_ADDR_LEN + LINE_ADDR_LEN);

    logic [31:0]      data_q  [0:NWORDS-1];
    logic [TAG_W-1:0] tag_q   [0:NSETS-1];
    logic [NSETS-1:0] valid_q, valid_d;
    logic [NSETS-1:0] dirty_q, dirty_d;
    logic [31:0]      data_d;

    assign rd_valid = valid_q[rd_set];
    assign rd_dirty = dirty_q[rd_set];
    assign rd_tag   = tag_q[rd_set];
    assign rd_dat   = data_q[{rd_set, rd_word}];

    // Byte-merge the incoming word over the stored one.
    always_comb begin
        data_d = data_q[{wr_set, wr_word}];
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) data_d[8*b +: 8] = wr_dat[8*b +: 8];
        end
    end

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (meta_vld) begin
            valid_d[wr_set] = meta_valid;
            dirty_d[wr_set] = meta_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_word_vld) data_q[{wr_set, wr_word}] <= data_d;
        if (meta_vld)    tag_q[wr_set]             <= meta_tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller; optional hit/miss counters via DCACHE_STATS_EN.
// Zero-latency hit; a miss costs one lookup cycle plus one cycle per acked word (writeback then fill).
// Stalls the pipeline through DCacheMiss; each memory word request is held until MemAck.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
    parameter int SET_ADDR_LEN  = SET_ADDR_LEN_DEF
) (
    input  logic        clk,
    input  logic        CpuRstN,
    input  logic        RdReq,
    input  logic        WrReq,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    input  logic [3:0]  WrByteEn,
    output logic [31:0] RdData,
    output logic        DCacheMiss,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWrData,
    input  logic        MemAck,
    input  logic [31:0] MemRdData
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] HitCnt,
    output logic [31:0] MissCnt
`endif
);
    localparam int TAG_W = tag_len(SET_ADDR_LEN, LINE_ADDR_LEN);

    logic [TAG_W-1:0]         req_tag;
    logic [SET_ADDR_LEN-1:0]  req_set;
    logic [LINE_ADDR_LEN-1:0] req_off;
    logic                     unused_addr;

    assign req_tag     = Addr[31 -: TAG_W];
    assign req_set     = Addr[SET_ADDR_LEN+LINE_ADDR_LEN+1 : LINE_ADDR_LEN+2];
    assign req_off     = Addr[LINE_ADDR_LEN+1:2];
    assign unused_addr = ^Addr[1:0];

    logic [1:0]               state_q, state_d;
    logic [LINE_ADDR_LEN-1:0] cnt_q, cnt_d;
    logic [SET_ADDR_LEN-1:0]  miss_set_q, miss_set_d;
    logic [TAG_W-1:0]         miss_tag_q, miss_tag_d;

    logic                     req, hit, in_idle, last, fill_wr;
    logic [SET_ADDR_LEN-1:0]  rd_set;
    logic [LINE_ADDR_LEN-1:0] rd_word;
    logic                     rd_valid, rd_dirty;
    logic [TAG_W-1:0]         rd_tag;
    logic [31:0]              rd_dat;

    // Outside IDLE the RAM port follows the latched miss line, so a withdrawn request cannot disturb it.
    assign in_idle = (state_q == ST_IDLE);
    assign rd_set  = in_idle ? req_set : miss_set_q;
    assign rd_word = in_idle ? req_off : cnt_q;

    assign req        = RdReq | WrReq;
    assign hit        = req & rd_valid & (rd_tag == req_tag) & in_idle;
    assign DCacheMiss = req & ~hit;
    assign RdData     = hit ? rd_dat : 32'h0;
    assign last       = &cnt_q;
    assign fill_wr    = (state_q == ST_FILL) & MemAck;

    always_comb begin
        state_d    = state_q;
        miss_set_d = miss_set_q;
        miss_tag_d = miss_tag_q;
        case (state_q)
            ST_IDLE: if (req && !hit) begin
                miss_set_d = req_set;
                miss_tag_d = req_tag;
                state_d    = (rd_valid && rd_dirty) ? ST_WB : ST_FILL;
            end
            ST_WB:   if (MemAck && last) state_d = ST_FILL;
            ST_FILL: if (MemAck && last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q)        cnt_d = '0;
        else if (MemAck && !in_idle)   cnt_d = cnt_q + 1'b1;
        else                           cnt_d = cnt_q;
    end

    always_ff @(posedge clk or negedge CpuRstN) begin
        if (!CpuRstN) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            miss_set_q <= '0;
            miss_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            miss_set_q <= miss_set_d;
            miss_tag_q <= miss_tag_d;
        end
    end

    // The victim tag stays readable through WB because the tag only changes at fill completion.
    always_comb begin
        MemReq    = !in_idle;
        MemWe     = (state_q == ST_WB);
        MemAddr   = 32'h0;
        MemWrData = 32'h0;
        if (state_q == ST_WB) begin
            MemAddr   = {rd_tag, miss_set_q, cnt_q, 2'b00};
            MemWrData = rd_dat;
        end else if (state_q == ST_FILL) begin
            MemAddr   = {miss_tag_q, miss_set_q, cnt_q, 2'b00};
        end
    end

    dcache_line_ram #(
        .LINE_ADDR_LEN (LINE_ADDR_LEN),
        .SET_ADDR_LEN  (SET_ADDR_LEN),
        .TAG_W         (TAG_W)
    ) u_ram (
        .clk         (clk),
        .rst_n       (CpuRstN),
        .rd_set      (rd_set),
        .rd_word     (rd_word),
        .rd_valid    (rd_valid),
        .rd_dirty    (rd_dirty),
        .rd_tag      (rd_tag),
        .rd_dat      (rd_dat),
        .wr_word_vld (fill_wr | (hit & WrReq)),
        .wr_set      (rd_set),
        .wr_word     (rd_word),
        .wr_dat      (fill_wr ? MemRdData : WrData),
        .wr_be       (fill_wr ? 4'hF : WrByteEn),
        .meta_vld    ((fill_wr & last) | (hit & WrReq)),
        .meta_valid  (1'b1),
        .meta_dirty  (~fill_wr),
        .meta_tag    (fill_wr ? miss_tag_q : req_tag)
    );

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        fill_done_q, fill_done_d;

    // The replayed request that hits right after a fill belongs to the miss already counted.
    always_comb begin
        fill_done_d = fill_wr & last;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        if (hit && !fill_done_q && hit_cnt_q != 32'hFFFF_FFFF)              hit_cnt_d  = hit_cnt_q + 32'd1;
        if (in_idle && req && !hit && miss_cnt_q != 32'hFFFF_FFFF)          miss_cnt_d = miss_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge CpuRstN) begin
        if (!CpuRstN) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            fill_done_q <= 1'b0;
        end else begin
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            fill_done_q <= fill_done_d;
        end
    end

    assign HitCnt  = hit_cnt_q;
    assign MissCnt = miss_cnt_q;
`endif

endmodule
